// File: rtl/dso_sram_pkg.sv
// Shared definitions for the DSO SRAM arbiter: FSM state encoding,
// default bus widths and the strobe timer width.
package dso_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        TURN = 2'd3
    } state_t;

    localparam int DEF_AW = 18;
    localparam int DEF_DW = 16;
    localparam int TW     = 4;

endpackage

// File: rtl/sram_cyc_timer.sv
// Loadable down-counter that times the SRAM strobe phases; 'last' is high
// while the count sits at zero, i.e. during the final cycle of a phase.
module sram_cyc_timer
    import dso_sram_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          last
);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/sram_arb.sv
// Arbiter/sequencer for the shared asynchronous SRAM: latches capture writes and
// SPI reads, grants writes first, and drives registered strobes. Optional macro:
// SRAM_ARB_STARVE_EN forces a read grant after STARVE_LIM consecutive write grants.
module sram_arb
    import dso_sram_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int WR_CYC     = 1,
    parameter int RD_CYC     = 2,
    parameter int STARVE_LIM = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          wr_done,
    output logic          ovf,
    input  logic          ovf_clr,
    output logic          busy,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dout,
    input  logic [DW-1:0] sram_din,
    output logic          sram_doe,
    output logic          sram_nce,
    output logic          sram_noe,
    output logic          sram_nwe
);

    localparam logic [TW-1:0] WR_LOAD = TW'(WR_CYC - 1);
    localparam logic [TW-1:0] RD_LOAD = TW'(RD_CYC - 1);

    state_t        state;
    logic          wr_pend;
    logic          rd_pend;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic [AW-1:0] rd_addr_q;
    logic          wr_grant;
    logic          rd_grant;
    logic          force_rd;
    logic          ovf_set;
    logic          tmr_last;

    assign wr_grant = (state == IDLE) && wr_pend && !force_rd;
    assign rd_grant = (state == IDLE) && rd_pend && (!wr_pend || force_rd);

    // A request landing on a pending flag that is not being granted is lost.
    assign ovf_set = (wr_req && wr_pend && !wr_grant) ||
                     (rd_req && rd_pend && !rd_grant);

    assign busy = (state != IDLE) || wr_pend || rd_pend;

`ifdef SRAM_ARB_STARVE_EN
    logic [4:0] starve_cnt;

    assign force_rd = rd_pend && (starve_cnt >= 5'(STARVE_LIM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!rd_pend || rd_grant) begin
            starve_cnt <= '0;
        end else if (wr_grant && (starve_cnt != 5'h1f)) begin
            starve_cnt <= starve_cnt + 5'd1;
        end
    end
`else
    // Strict write priority; STARVE_LIM has no effect in this build.
    assign force_rd = 1'b0 & (STARVE_LIM != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pend   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (wr_req && (!wr_pend || wr_grant)) begin
            wr_pend   <= 1'b1;
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
        end else if (wr_grant) begin
            wr_pend   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend   <= 1'b0;
            rd_addr_q <= '0;
        end else if (rd_req && (!rd_pend || rd_grant)) begin
            rd_pend   <= 1'b1;
            rd_addr_q <= rd_addr;
        end else if (rd_grant) begin
            rd_pend   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end
    end

    sram_cyc_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (wr_grant || rd_grant),
        .load_val (wr_grant ? WR_LOAD : RD_LOAD),
        .last     (tmr_last)
    );

    // Strobes are decoded into flops on each transition so the bus never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sram_addr <= '0;
            sram_dout <= '0;
            sram_doe  <= 1'b0;
            sram_nce  <= 1'b1;
            sram_noe  <= 1'b1;
            sram_nwe  <= 1'b1;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            wr_done   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_grant) begin
                        state     <= WR;
                        sram_addr <= wr_addr_q;
                        sram_dout <= wr_data_q;
                        sram_doe  <= 1'b1;
                        sram_nce  <= 1'b0;
                        sram_nwe  <= 1'b0;
                    end else if (rd_grant) begin
                        state     <= RD;
                        sram_addr <= rd_addr_q;
                        sram_nce  <= 1'b0;
                        sram_noe  <= 1'b0;
                    end
                end
                WR: begin
                    if (tmr_last) begin
                        state    <= TURN;
                        sram_doe <= 1'b0;
                        sram_nce <= 1'b1;
                        sram_nwe <= 1'b1;
                        wr_done  <= 1'b1;
                    end
                end
                RD: begin
                    if (tmr_last) begin
                        state    <= TURN;
                        sram_nce <= 1'b1;
                        sram_noe <= 1'b1;
                        rd_data  <= sram_din;
                        rd_valid <= 1'b1;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arb.sv
// Directed self-checking bench for sram_arb; expected values are hand-derived
// cycle counts (edge 1 is the edge that samples the request).
module tb_sram_arb;

    logic        clk;
    logic        rst;
    logic        wr_req;
    logic [17:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [17:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        wr_done;
    logic        ovf;
    logic        ovf_clr;
    logic        busy;
    logic [17:0] sram_addr;
    logic [15:0] sram_dout;
    logic [15:0] sram_din;
    logic        sram_doe;
    logic        sram_nce;
    logic        sram_noe;
    logic        sram_nwe;
    logic [15:0] model_rd;

    int tests;
    int fails;

    sram_arb #(
        .AW(18), .DW(16), .WR_CYC(1), .RD_CYC(2), .STARVE_LIM(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_done   (wr_done),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .busy      (busy),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout),
        .sram_din  (sram_din),
        .sram_doe  (sram_doe),
        .sram_nce  (sram_nce),
        .sram_noe  (sram_noe),
        .sram_nwe  (sram_nwe)
    );

    // SRAM model: returns model_rd only while the chip is output-enabled.
    assign sram_din = (!sram_nce && !sram_noe) ? model_rd : 16'hDEAD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_req = 0; wr_addr = '0; wr_data = '0;
        rd_req = 0; rd_addr = '0; ovf_clr = 0; model_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tests++;
        if ({sram_nce, sram_noe, sram_nwe, sram_doe} !== 4'b1110) begin
            fails++;
            $display("[TB] FAIL reset_strobes: got %b expected %b", {sram_nce, sram_noe, sram_nwe, sram_doe}, 4'b1110);
        end
        tests++;
        if ({sram_addr, sram_dout, rd_data} !== 50'd0) begin
            fails++;
            $display("[TB] FAIL reset_regs: got %h expected 0", {sram_addr, sram_dout, rd_data});
        end
        tests++;
        if ({rd_valid, wr_done, ovf, busy} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {rd_valid, wr_done, ovf, busy});
        end
    endtask

    task automatic test_single_write();
        wr_req = 1; wr_addr = 18'h00010; wr_data = 16'hA55A;
        tick();
        wr_req = 0;
        tests++;
        if ({sram_nce, sram_noe, sram_nwe, sram_doe, busy} !== 5'b11101) begin
            fails++;
            $display("[TB] FAIL wr_latch: got %b expected %b", {sram_nce, sram_noe, sram_nwe, sram_doe, busy}, 5'b11101);
        end
        tick();
        tests++;
        if ({sram_nce, sram_noe, sram_nwe, sram_doe, wr_done} !== 5'b01010) begin
            fails++;
            $display("[TB] FAIL wr_strobes: got %b expected %b", {sram_nce, sram_noe, sram_nwe, sram_doe, wr_done}, 5'b01010);
        end
        tests++;
        if (sram_addr !== 18'h00010 || sram_dout !== 16'hA55A) begin
            fails++;
            $display("[TB] FAIL wr_bus: got addr %h data %h expected addr 00010 data a55a", sram_addr, sram_dout);
        end
        tick();
        tests++;
        if ({sram_nce, sram_noe, sram_nwe, sram_doe, wr_done} !== 5'b11101) begin
            fails++;
            $display("[TB] FAIL wr_turn: got %b expected %b", {sram_nce, sram_noe, sram_nwe, sram_doe, wr_done}, 5'b11101);
        end
        tick();
        tests++;
        if ({sram_nce, sram_noe, sram_nwe, sram_doe, wr_done, busy} !== 6'b111000) begin
            fails++;
            $display("[TB] FAIL wr_idle: got %b expected %b", {sram_nce, sram_noe, sram_nwe, sram_doe, wr_done, busy}, 6'b111000);
        end
    endtask

    task automatic test_single_read();
        int noe_cnt = 0, first_noe = -1, valid_cnt = 0, valid_edge = -1;
        logic [17:0] addr_at = '0;
        logic [15:0] data_at = '0;
        model_rd = 16'h1234;
        rd_req = 1; rd_addr = 18'h3FFFF;
        for (int e = 1; e <= 6; e++) begin
            tick();
            rd_req = 0;
            if (!sram_noe) begin
                noe_cnt++;
                if (first_noe < 0) begin first_noe = e; addr_at = sram_addr; end
            end
            if (rd_valid) begin valid_cnt++; valid_edge = e; data_at = rd_data; end
        end
        tests++;
        if (noe_cnt != 2 || first_noe != 2) begin
            fails++;
            $display("[TB] FAIL rd_noe: got %0d cycles from edge %0d expected 2 cycles from edge 2", noe_cnt, first_noe);
        end
        tests++;
        if (addr_at !== 18'h3FFFF) begin
            fails++;
            $display("[TB] FAIL rd_addr: got %h expected 3ffff", addr_at);
        end
        tests++;
        if (valid_cnt != 1 || valid_edge != 4) begin
            fails++;
            $display("[TB] FAIL rd_latency: got %0d pulses at edge %0d expected 1 at edge 4", valid_cnt, valid_edge);
        end
        tests++;
        if (data_at !== 16'h1234) begin
            fails++;
            $display("[TB] FAIL rd_data: got %h expected 1234", data_at);
        end
    endtask

    task automatic test_simultaneous();
        int first_nwe = -1, first_noe = -1, valid_edge = -1;
        logic [15:0] data_at = '0;
        logic [17:0] addr_at = '0;
        model_rd = 16'hBEEF;
        wr_req = 1; wr_addr = 18'h00020; wr_data = 16'h0F0F;
        rd_req = 1; rd_addr = 18'h00030;
        for (int e = 1; e <= 10; e++) begin
            tick();
            wr_req = 0; rd_req = 0;
            if (!sram_nwe && first_nwe < 0) first_nwe = e;
            if (!sram_noe && first_noe < 0) begin first_noe = e; addr_at = sram_addr; end
            if (rd_valid && valid_edge < 0) begin valid_edge = e; data_at = rd_data; end
        end
        tests++;
        if (first_nwe != 2 || first_noe != 5) begin
            fails++;
            $display("[TB] FAIL sim_order: got nwe edge %0d noe edge %0d expected 2 and 5", first_nwe, first_noe);
        end
        tests++;
        if (valid_edge != 7 || data_at !== 16'hBEEF || addr_at !== 18'h00030) begin
            fails++;
            $display("[TB] FAIL sim_read: got edge %0d data %h addr %h expected edge 7 data beef addr 00030", valid_edge, data_at, addr_at);
        end
    endtask

    task automatic test_overflow();
        logic [33:0] wq[$];
        logic [33:0] got, exp;
        logic ovf_at5 = 1'bx, ovf_at7 = 1'bx;
        int n, k;
        wr_req = 1; wr_addr = 18'd1; wr_data = 16'h1111;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (!sram_nwe) wq.push_back({sram_addr, sram_dout});
            if (e == 5) ovf_at5 = ovf;
            if (e == 7) ovf_at7 = ovf;
            n = e + 1;
            if (n == 3 || n == 5 || n == 7) begin
                k = (n + 1) / 2;
                wr_req = 1; wr_addr = 18'(k); wr_data = {4{4'(k)}};
            end else begin
                wr_req = 0;
            end
        end
        tests++;
        if (ovf_at5 !== 1'b0 || ovf_at7 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ovf_set: got %b at edge 5 and %b at edge 7 expected 0 and 1", ovf_at5, ovf_at7);
        end
        tests++;
        if (wq.size() != 3) begin
            fails++;
            $display("[TB] FAIL ovf_wr_count: got %0d writes expected 3", wq.size());
        end
        for (int i = 0; i < 3; i++) begin
            exp = {18'(i + 1), {4{4'(i + 1)}}};
            got = (i < wq.size()) ? wq[i] : '1;
            tests++;
            if (got !== exp) begin
                fails++;
                $display("[TB] FAIL ovf_wr_%0d: got %h expected %h", i, got, exp);
            end
        end
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        tests++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ovf_clr: got %b expected 0", ovf);
        end
        wr_req = 1; wr_addr = 18'h00100; wr_data = 16'hAAAA;
        tick();
        wr_req = 0;
        tick();
        wr_req = 1; wr_addr = 18'h00101; wr_data = 16'hBBBB;
        tick();
        wr_req = 1; wr_addr = 18'h00102; wr_data = 16'hCCCC; ovf_clr = 1;
        tick();
        wr_req = 0; ovf_clr = 0;
        tests++;
        if (ovf !== 1'b0) begin
            fails++;
            $display("[TB] FAIL ovf_set_clr: got %b expected 0", ovf);
        end
        repeat (6) tick();
    endtask

    task automatic test_reset_mid_read();
        logic saw_valid = 1'b0;
        model_rd = 16'h5555;
        rd_req = 1; rd_addr = 18'h00100;
        tick();
        rd_req = 0;
        tick();
        tests++;
        if (sram_noe !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rst_pre_noe: got %b expected 0", sram_noe);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({sram_nce, sram_noe} !== 2'b11) begin
            fails++;
            $display("[TB] FAIL rst_async: got %b expected 11", {sram_nce, sram_noe});
        end
        repeat (2) begin tick(); saw_valid |= rd_valid; end
        rst = 1'b0;
        repeat (4) begin tick(); saw_valid |= rd_valid; end
        tests++;
        if (saw_valid !== 1'b0 || busy !== 1'b0 || rd_data !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL rst_abort: got valid %b busy %b data %h expected 0 0 0000", saw_valid, busy, rd_data);
        end
        tests++;
        if ({sram_nce, sram_noe, sram_nwe, sram_doe} !== 4'b1110) begin
            fails++;
            $display("[TB] FAIL rst_idle: got %b expected 1110", {sram_nce, sram_noe, sram_nwe, sram_doe});
        end
    endtask

    task automatic test_starvation();
        int first_noe = -1, wr_before = 0, n;
        int exp_first, exp_wr;
`ifdef SRAM_ARB_STARVE_EN
        exp_first = 14; exp_wr = 4;
`else
        exp_first = 26; exp_wr = 8;
`endif
        model_rd = 16'h7777;
        wr_req = 1; wr_addr = 18'h00200; wr_data = 16'h0001;
        rd_req = 1; rd_addr = 18'h00300;
        for (int e = 1; e <= 30; e++) begin
            tick();
            rd_req = 0;
            if (!sram_noe && first_noe < 0) first_noe = e;
            if (!sram_nwe && first_noe < 0) wr_before++;
            n = e + 1;
            wr_req = ((n % 3) == 1) && (n <= 22);
            wr_addr = 18'h00200 + 18'(n);
            wr_data = 16'(n);
        end
        wr_req = 0;
        tests++;
        if (first_noe != exp_first) begin
            fails++;
            $display("[TB] FAIL starve_rd_edge: got %0d expected %0d", first_noe, exp_first);
        end
        tests++;
        if (wr_before != exp_wr) begin
            fails++;
            $display("[TB] FAIL starve_wr_count: got %0d expected %0d", wr_before, exp_wr);
        end
        repeat (12) tick();
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_write();
        test_single_read();
        test_simultaneous();
        test_overflow();
        test_reset_mid_read();
        test_starvation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_arb.md
Name: sram_arb

Overview:
- Sequences all accesses to the single shared asynchronous SRAM.
- Two requesters: the capture path writes one 16-bit sample per request; the SPI register read path requests one word.
- Latches requests, arbitrates with write priority, times the SRAM strobes, and returns registered read data.
- Replaces the ad-hoc read/write status logic in the DSO top level.

Parameters:
- AW, 18, SRAM address width
- DW, 16, SRAM data width
- WR_CYC, 1, cycles nwe held low per write (1..15)
- RD_CYC, 2, cycles noe held low per read; data sampled at end of last cycle (1..15)
- STARVE_LIM, 16, consecutive write grants before a forced read (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_req  in  1  single-cycle capture write request
- wr_addr  in  AW  write address, valid with wr_req
- wr_data  in  DW  write data, valid with wr_req
- rd_req  in  1  single-cycle SPI read request
- rd_addr  in  AW  read address, valid with rd_req
- rd_data  out  DW  registered read data
- rd_valid  out  1  one-cycle pulse; rd_data updated
- wr_done  out  1  one-cycle pulse at the end of each write access
- ovf  out  1  sticky: a request was lost
- ovf_clr  in  1  clears ovf
- busy  out  1  state != IDLE or any request pending
- sram_addr  out  AW  registered SRAM address
- sram_dout  out  DW  data to drive on the bus
- sram_din  in  DW  data from the bus
- sram_doe  out  1  bus drive enable for the top-level tristate
- sram_nce  out  1  active-low chip enable
- sram_noe  out  1  active-low output enable
- sram_nwe  out  1  active-low write enable

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-high.
- Reset values:
  - sram_nce, sram_noe, sram_nwe = 1; sram_doe = 0.
  - sram_addr, sram_dout, rd_data = 0; rd_valid, wr_done, ovf = 0.
  - Pending flags cleared; state IDLE.
- Reset mid-access aborts the access immediately; strobes go high asynchronously and nothing is retried.
- Request latching:
  - A request sets its pending flag and captures address/data in the same edge.
  - Request while the same flag is already pending and not being granted this cycle: new request dropped, older one kept, ovf set.
  - Request in the same cycle its pending flag is consumed by a grant: new request captured, flag stays 1, no ovf.
- States:
  - IDLE:
    - wr_pend → WR (write priority).
    - else rd_pend → RD.
    - else stay.
    - On grant: sram_addr loads the pending address, the pending flag clears, the timer loads cycle count − 1.
  - WR:
    - sram_nce = 0, sram_nwe = 0, sram_doe = 1, sram_dout = captured data, for WR_CYC cycles.
    - On the last cycle, wr_done pulses the following cycle; next state TURN.
  - RD:
    - sram_nce = 0, sram_noe = 0 for RD_CYC cycles.
    - On the last cycle's edge, rd_data ← sram_din; rd_valid = 1 the next cycle; next state TURN.
  - TURN:
    - One cycle with all strobes high and sram_doe = 0, for bus turnaround. Then → IDLE.
- All SRAM outputs are registered (state-decoded into flops, no combinational glitch).
- Throughput:
  - Write-to-write minimum spacing is WR_CYC + 2 cycles (IDLE + WR + TURN).
  - Capture must not request faster than that; if it does, ovf flags it.
- Read latency, rd_req to rd_valid, no contention: 1 (latch) + RD_CYC + 1 (TURN) cycles = 4 with defaults.
- Reads wait while writes are pending (unbounded without the optional feature).
- ovf_clr has priority over a same-cycle ovf set.
- busy is combinational from state and pending flags.

Optional Feature:
- Macro SRAM_ARB_STARVE_EN.
- Defined:
  - A 5-bit counter counts consecutive write grants while rd_pend = 1; it clears on any read grant or when rd_pend = 0.
  - When the count reaches STARVE_LIM, the next IDLE grant goes to the read even if wr_pend = 1. The write stays pending; if a further wr_req arrives in the meantime, ovf rules apply.
- Undefined: strict write priority; counter logic absent.

Decomposition:
- Package dso_sram_pkg holds:
  - state encoding: IDLE, WR, RD, TURN (2-bit);
  - default widths AW, DW;
  - timer width constant (4 bits).
- One sub-module, sram_cyc_timer: loadable 4-bit down-counter with a last-cycle flag, shared by WR and RD.

Test Plan:
- Single write: wr_req, addr 0x00010, data 0xA55A, defaults → nwe low exactly 1 cycle; sram_addr = 0x00010, sram_dout = 0xA55A, doe = 1 during it; wr_done 1 cycle later; bus idle next cycle.
- Single read: rd_req, addr 0x3FFFF, model returns 0x1234 → noe low 2 cycles; rd_valid pulses at cycle 4 after rd_req with rd_data = 0x1234.
- Simultaneous wr_req and rd_req → write performed first; read starts right after TURN; rd_valid 7 cycles after the requests.
- Writes every 2 cycles (faster than the 3-cycle limit) → ovf set on the second overlapping request; older data written; ovf_clr clears it; same-cycle set and clear leaves ovf = 0.
- Reset asserted during RD cycle 1 → nce/noe high immediately, no rd_valid; after release the block is IDLE with no pending requests.
- With SRAM_ARB_STARVE_EN, STARVE_LIM = 4, continuous writes and a pending read → read granted after the 4th write grant. Without the macro, no read is granted until writes stop.
